// File: rtl/eth_header_tx.sv
// Byte-serial Ethernet header transmitter: [preamble/SFD], dest MAC, src MAC, EtherType, MSB-first.
// Optional preamble/SFD generation is built when ETH_HDR_TX_PREAMBLE_EN is defined.
module eth_header_tx #(
  parameter logic [15:0] ETH_ARP_TYPE = 16'h0806,
  parameter logic [15:0] ETH_IP_TYPE  = 16'h0800
`ifdef ETH_HDR_TX_PREAMBLE_EN
  ,
  parameter int          PREAMBLE_LEN = 7
`endif
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        start,
  input  logic        eth_type_sel,
  input  logic [47:0] mac_d_addr,
  input  logic [47:0] mac_s_addr,
  input  logic        abort,
  input  logic        data_ready,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic        busy,
  output logic        header_done
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    SFD      = 3'd2,
    MAC_DEST = 3'd3,
    MAC_SRC  = 3'd4,
    ETH_TYPE = 3'd5
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic        header_done_nxt;
  logic        load;
  logic        xfer;
  logic [47:0] dest_q, src_q;
  logic [15:0] type_q;
  logic [47:0] dest_sh, src_sh;

  assign xfer       = data_valid && data_ready;
  assign data_valid = (state != IDLE);
  assign busy       = (state != IDLE);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state       <= IDLE;
      cnt         <= 3'd0;
      header_done <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      header_done <= header_done_nxt;
    end
  end

  // Header fields only change in IDLE, so they need no reset.
  always_ff @(posedge aclk) begin
    if (load) begin
      dest_q <= eth_type_sel ? 48'hFFFF_FFFF_FFFF : mac_d_addr;
      src_q  <= mac_s_addr;
      type_q <= eth_type_sel ? ETH_ARP_TYPE : ETH_IP_TYPE;
    end
  end

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    header_done_nxt = 1'b0;
    load            = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
      cnt_nxt   = 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            load    = 1'b1;
            cnt_nxt = 3'd0;
`ifdef ETH_HDR_TX_PREAMBLE_EN
            state_nxt = PREAMBLE;
`else
            state_nxt = MAC_DEST;
`endif
          end
        end
`ifdef ETH_HDR_TX_PREAMBLE_EN
        PREAMBLE: begin
          if (xfer) begin
            if (cnt == 3'(PREAMBLE_LEN - 1)) begin
              state_nxt = SFD;
              cnt_nxt   = 3'd0;
            end else begin
              cnt_nxt = cnt + 3'd1;
            end
          end
        end
        SFD: begin
          if (xfer) begin
            state_nxt = MAC_DEST;
            cnt_nxt   = 3'd0;
          end
        end
`endif
        MAC_DEST: begin
          if (xfer) begin
            if (cnt == 3'd5) begin
              state_nxt = MAC_SRC;
              cnt_nxt   = 3'd0;
            end else begin
              cnt_nxt = cnt + 3'd1;
            end
          end
        end
        MAC_SRC: begin
          if (xfer) begin
            if (cnt == 3'd5) begin
              state_nxt = ETH_TYPE;
              cnt_nxt   = 3'd0;
            end else begin
              cnt_nxt = cnt + 3'd1;
            end
          end
        end
        ETH_TYPE: begin
          if (xfer) begin
            if (cnt == 3'd1) begin
              state_nxt       = IDLE;
              cnt_nxt         = 3'd0;
              header_done_nxt = 1'b1;
            end else begin
              cnt_nxt = cnt + 3'd1;
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = 3'd0;
        end
      endcase
    end
  end

  // Shift the selected MAC so the current byte always sits in the top octet.
  assign dest_sh = dest_q << {cnt, 3'b000};
  assign src_sh  = src_q << {cnt, 3'b000};

  always_comb begin
    data_out = 8'h00;
    case (state)
`ifdef ETH_HDR_TX_PREAMBLE_EN
      PREAMBLE: data_out = 8'h55;
      SFD:      data_out = 8'hD5;
`endif
      MAC_DEST: data_out = dest_sh[47:40];
      MAC_SRC:  data_out = src_sh[47:40];
      ETH_TYPE: data_out = (cnt == 3'd0) ? type_q[15:8] : type_q[7:0];
      default:  data_out = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_eth_header_tx.sv
// Self-checking bench for eth_header_tx: vector table plus hand-written backpressure/abort/reset sequences.
module tb_eth_header_tx;

`ifdef ETH_HDR_TX_PREAMBLE_EN
  localparam int OFF = 8;
`else
  localparam int OFF = 0;
`endif
  localparam int NBYTES = OFF + 14;

  logic        aclk;
  logic        aresetn;
  logic        start;
  logic        eth_type_sel;
  logic [47:0] mac_d_addr;
  logic [47:0] mac_s_addr;
  logic        abort;
  logic        data_ready;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        busy;
  logic        header_done;

  eth_header_tx dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .start        (start),
    .eth_type_sel (eth_type_sel),
    .mac_d_addr   (mac_d_addr),
    .mac_s_addr   (mac_s_addr),
    .abort        (abort),
    .data_ready   (data_ready),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .busy         (busy),
    .header_done  (header_done)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  typedef struct packed {
    logic [7:0] b;
    logic       last;
  } exp_t;

  typedef struct {
    logic        sel;
    logic [47:0] d;
    logic [47:0] s;
    logic [7:0]  exp_first_dest;
    logic [7:0]  exp_last;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;
  logic exp_hd = 1'b0;

  function automatic void chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void push_frame(input logic sel, input logic [47:0] d, input logic [47:0] s);
    logic [47:0] dd;
    logic [15:0] t;
    dd = sel ? 48'hFFFF_FFFF_FFFF : d;
    t  = sel ? 16'h0806 : 16'h0800;
    for (int i = 0; i < OFF - 1; i++) sb.push_back('{b: 8'h55, last: 1'b0});
    if (OFF > 0) sb.push_back('{b: 8'hD5, last: 1'b0});
    for (int i = 0; i < 6; i++) sb.push_back('{b: dd[47 - 8*i -: 8], last: 1'b0});
    for (int i = 0; i < 6; i++) sb.push_back('{b: s[47 - 8*i -: 8], last: 1'b0});
    sb.push_back('{b: t[15:8], last: 1'b0});
    sb.push_back('{b: t[7:0], last: 1'b1});
  endfunction

  // Scoreboard monitor: every transferred byte is popped and compared.
  always @(negedge aclk) begin
    if (mon_en) begin
      chk("header_done", {47'd0, header_done}, {47'd0, exp_hd});
      exp_hd = 1'b0;
      if (data_valid && data_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %h, expected no transfer (t=%0t)", data_out, $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("stream_byte", {40'd0, data_out}, {40'd0, e.b});
          exp_hd = e.last;
        end
      end
    end
  end

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic begin_frame(input logic sel, input logic [47:0] d, input logic [47:0] s);
    start        = 1'b1;
    eth_type_sel = sel;
    mac_d_addr   = d;
    mac_s_addr   = s;
    push_frame(sel, d, s);
    tick();
    start = 1'b0;
  endtask

  // Returns at the negedge of the header_done cycle (or after the budget expires).
  task automatic wait_hd;
    int cyc;
    cyc = 0;
    @(negedge aclk);
    while (header_done !== 1'b1 && cyc < 300) begin
      cyc++;
      @(negedge aclk);
    end
    chk("wait_hd_timeout", {47'd0, header_done === 1'b1}, 48'd1);
  endtask

  task automatic run_frame(input logic sel, input logic [47:0] d, input logic [47:0] s,
                           output logic [7:0] fd, output logic [7:0] ld, output int cyc);
    logic got;
    got = 1'b0;
    fd  = 8'h00;
    ld  = 8'h00;
    cyc = 0;
    begin_frame(sel, d, s);
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge aclk);
      if (header_done === 1'b1) begin
        got = 1'b1;
      end else begin
        if (cyc == OFF) fd = data_out;
        ld = data_out;
        cyc++;
      end
    end
    chk("run_frame_timeout", {47'd0, got}, 48'd1);
    tick();
  endtask

  vec_t vecs[4];

  initial begin
    logic [7:0] fd, ld;
    int cyc;

    vecs[0] = '{1'b0, 48'h0211_2233_4455, 48'h02AA_BBCC_DDEE, 8'h02, 8'h00};
    vecs[1] = '{1'b1, 48'h0211_2233_4455, 48'h02AA_BBCC_DDEE, 8'hFF, 8'h06};
    vecs[2] = '{1'b0, 48'hA1B2_C3D4_E5F6, 48'h0000_0000_0001, 8'hA1, 8'h00};
    vecs[3] = '{1'b1, 48'h0000_0000_0000, 48'hFFFF_FFFF_FFFF, 8'hFF, 8'h06};

    aresetn      = 1'b0;
    start        = 1'b0;
    eth_type_sel = 1'b0;
    mac_d_addr   = '0;
    mac_s_addr   = '0;
    abort        = 1'b0;
    data_ready   = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    @(negedge aclk);
    chk("reset_data_out", {40'd0, data_out}, 48'd0);
    chk("reset_data_valid", {47'd0, data_valid}, 48'd0);
    chk("reset_busy", {47'd0, busy}, 48'd0);
    chk("reset_header_done", {47'd0, header_done}, 48'd0);
    mon_en = 1'b1;
    tick();
    aresetn = 1'b1;
    tick();

    // Table: each header must run back-to-back with no gap, header_done right after.
    for (int v = 0; v < 4; v++) begin
      run_frame(vecs[v].sel, vecs[v].d, vecs[v].s, fd, ld, cyc);
      chk("vec_first_dest", {40'd0, fd}, {40'd0, vecs[v].exp_first_dest});
      chk("vec_last_type", {40'd0, ld}, {40'd0, vecs[v].exp_last});
      chk("vec_cycles", cyc, NBYTES);
      chk("vec_busy_idle", {47'd0, busy}, 48'd0);
    end

    // Backpressure on the second source byte.
    begin_frame(1'b0, 48'h0211_2233_4455, 48'h02AA_BBCC_DDEE);
    repeat (OFF + 7) tick();
    data_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      chk("stall_data_out", {40'd0, data_out}, 48'hAA);
      chk("stall_data_valid", {47'd0, data_valid}, 48'd1);
      tick();
    end
    data_ready = 1'b1;
    wait_hd();
    tick();

    // start and mac_d changes mid-frame are ignored; restart on the header_done cycle.
    begin_frame(1'b0, 48'h0211_2233_4455, 48'h02AA_BBCC_DDEE);
    repeat (OFF + 6) tick();
    start        = 1'b1;
    eth_type_sel = 1'b1;
    mac_d_addr   = 48'hDEAD_BEEF_0000;
    tick();
    start = 1'b0;
    wait_hd();
    start        = 1'b1;
    eth_type_sel = 1'b0;
    mac_d_addr   = 48'h0A0B_0C0D_0E0F;
    mac_s_addr   = 48'h1112_1314_1516;
    push_frame(1'b0, 48'h0A0B_0C0D_0E0F, 48'h1112_1314_1516);
    tick();
    start = 1'b0;
    @(negedge aclk);
    chk("b2b_data_valid", {47'd0, data_valid}, 48'd1);
    chk("b2b_first_byte", {40'd0, data_out}, (OFF > 0) ? 48'h55 : 48'h0A);
    wait_hd();
    tick();

    // Abort on the third destination byte.
    begin_frame(1'b0, 48'h0211_2233_4455, 48'h02AA_BBCC_DDEE);
    repeat (OFF + 2) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge aclk);
    chk("abort_data_valid", {47'd0, data_valid}, 48'd0);
    chk("abort_busy", {47'd0, busy}, 48'd0);
    chk("abort_header_done", {47'd0, header_done}, 48'd0);
    chk("abort_remaining", sb.size(), 48'(NBYTES - OFF - 3));
    sb.delete();
    tick();
    run_frame(1'b1, 48'h0211_2233_4455, 48'h02AA_BBCC_DDEE, fd, ld, cyc);
    chk("post_abort_cycles", cyc, NBYTES);

    // Reset in the middle of the EtherType.
    begin_frame(1'b0, 48'h0211_2233_4455, 48'h02AA_BBCC_DDEE);
    repeat (OFF + 12) tick();
    aresetn = 1'b0;
    tick();
    @(negedge aclk);
    chk("rst_mid_data_out", {40'd0, data_out}, 48'd0);
    chk("rst_mid_data_valid", {47'd0, data_valid}, 48'd0);
    chk("rst_mid_busy", {47'd0, busy}, 48'd0);
    chk("rst_mid_header_done", {47'd0, header_done}, 48'd0);
    sb.delete();
    tick();
    aresetn = 1'b1;
    tick();
    run_frame(1'b0, 48'hA1B2_C3D4_E5F6, 48'h0000_0000_0001, fd, ld, cyc);
    chk("post_reset_first_dest", {40'd0, fd}, 48'hA1);
    chk("post_reset_cycles", cyc, NBYTES);

    repeat (3) tick();
    chk("sb_empty", sb.size(), 48'd0);
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
